stride_gather: RTL and testbench
================================

STRIDE_GATHER -- requirements
Module: stride_gather

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning width of the input vector (≥2).
REQ-002 SHALL have parameter CFG_W, default 3, meaning width of the stride and offset fields; 2^CFG_W ≥ LEN is required.
REQ-003 SHALL have parameter CNT_W, default $clog2(LEN+1), meaning width of the gathered-bit count.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_data  input  LEN  source vector.
REQ-007 in_valid / in_ready  input / output  1 each  request handshake; transfer when both are high at the clock edge.
REQ-008 cfg_stride, cfg_offset  input  CFG_W each  runtime stride and start index; sampled with in_data.
REQ-009 cfg_mode  input  1  0 = parallel result, 1 = serial stream; sampled with in_data.
REQ-010 par_out  output  LEN  packed gathered bits.
REQ-011 par_count  output  CNT_W  number of valid bits in par_out.
REQ-012 par_valid  output  1  one-cycle result strobe.
REQ-013 ser_bit, ser_valid, ser_last  output  1 each  serial stream data, valid and final-bit flag.
REQ-014 ser_ready  input  1  serial sink ready.
REQ-015 busy  output  1  high while in state SHIFT.
REQ-016 cfg_err  output  1  one-cycle strobe on a rejected configuration.

Function
REQ-017 Gathered index set SHALL be i_k = offset + k*stride for k = 0.., while i_k ≤ LEN-1; count N = floor((LEN-1-offset)/stride)+1.
REQ-018 Gathered bit k SHALL equal in_data[i_k] as latched at the accept edge; arithmetic SHALL be done at width sufficient to avoid overflow (no wrap of i_k).
REQ-019 FSM SHALL have two states, IDLE and SHIFT; in_ready = 1 only in IDLE.
REQ-020 A transfer with stride = 0 or offset ≥ LEN SHALL raise cfg_err for exactly the next cycle, produce no par_valid or ser_valid, and leave the FSM in IDLE.
REQ-021 Parallel mode: on the cycle after a transfer, par_valid = 1 for one cycle, par_out[k] = gathered bit k for k < N, par_out[LEN-1:N] = 0, par_count = N; FSM stays in IDLE, so one request per cycle is accepted (latency 1, throughput 1).
REQ-022 par_out and par_count SHALL hold their last values until the next parallel result or reset.
REQ-023 Serial mode: a transfer SHALL move the FSM to SHIFT; from the next cycle ser_valid = 1, ser_bit = gathered bit 0.
REQ-024 In SHIFT, ser_bit and ser_last SHALL be stable while ser_valid = 1 and ser_ready = 0; each cycle with ser_valid & ser_ready SHALL advance to the next bit.
REQ-025 ser_last SHALL be 1 exactly while the bit with k = N-1 is presented; N = 1 gives ser_last on the first bit.
REQ-026 The handshake on the last bit SHALL return the FSM to IDLE: ser_valid = 0 and in_ready = 1 in the following cycle; there is no bubble beyond that one cycle.
REQ-027 ser_valid SHALL be 0 whenever the FSM is in IDLE; par_valid SHALL never be asserted in SHIFT.
REQ-028 Changes on cfg_* or in_data while in SHIFT SHALL have no effect on the stream in progress.

Reset
REQ-029 With rst_n = 0 at a clock edge, the FSM SHALL enter IDLE and clear par_out, par_count, par_valid, ser_bit, ser_valid, ser_last, busy and cfg_err to 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 A reset asserted mid-stream SHALL abort the stream without emitting ser_last; no state SHALL persist.

Verification
REQ-031 LEN=8, parallel, in_data=0xB6, stride=2, offset=0 -> next cycle par_valid=1, par_out=0x06, par_count=4.
REQ-032 Serial, in_data=0x5A, stride=3, offset=1, ser_ready=1 -> ser_bit 1,1,0 on consecutive cycles, ser_last on the third bit, in_ready=1 on the cycle after that.
REQ-033 Same serial request with ser_ready=0 for 3 cycles on bit 1 -> bit 1 is held for 4 cycles with ser_valid=1, then the stream completes unchanged.
REQ-034 stride=0, and separately offset=7 with stride=5 -> first gives a cfg_err pulse and no output; second gives par_count=1 and par_out[0]=in_data[7].
REQ-035 Back-to-back parallel requests on 3 consecutive cycles -> 3 consecutive par_valid pulses with the matching results.
REQ-036 rst_n=0 during the second serial bit -> the next cycle has ser_valid=0, busy=0, in_ready=1, and all outputs are 0.

Source files
------------

// File: rtl/stride_gather.sv
// stride_gather: picks bits offset, offset+stride, ... out of an input vector
// and delivers them either as one packed word (parallel mode) or as a
// valid/ready bit stream (serial mode).
//
// Handshakes:
//   request : a transfer happens on a rising edge where in_valid && in_ready.
//             in_ready is high only in IDLE.
//   serial  : a bit is consumed on a rising edge where ser_valid && ser_ready.
//             While ser_valid is high and ser_ready is low, ser_bit and
//             ser_last hold their values.
//
// Debug visibility: busy is the FSM state (1 = SHIFT, 0 = IDLE).
module stride_gather #(
    parameter int LEN   = 8,
    parameter int CFG_W = 3,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN-1:0]   in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CFG_W-1:0] cfg_stride,
    input  logic [CFG_W-1:0] cfg_offset,
    input  logic             cfg_mode,
    output logic [LEN-1:0]   par_out,
    output logic [CNT_W-1:0] par_count,
    output logic             par_valid,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy,
    output logic             cfg_err
);

    // Index arithmetic width: offset + (LEN-1)*stride can never wrap here.
    localparam int IW = CFG_W + $clog2(LEN) + 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LEN-1:0]   par_out_q, par_out_d;
    logic [CNT_W-1:0] par_count_q, par_count_d;
    logic             par_valid_q, par_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic [LEN-1:0]   ser_data_q, ser_data_d;   // remaining bits, next one at [0]
    logic [CNT_W-1:0] ser_rem_q, ser_rem_d;     // bits still to be presented

    logic [LEN-1:0]   gath_vec;
    logic [CNT_W-1:0] gath_cnt;
    logic             cfg_ok;
    logic [IW-1:0]    idx;
    logic [LEN-1:0]   shifted;

    logic             accept;
    logic             take_par;
    logic             take_ser;
    logic             take_bad;
    logic             ser_hs;
    logic             on_last;

    // Gather network: packs every in-range index into consecutive result bits.
    always_comb begin
        gath_vec = '0;
        gath_cnt = '0;
        idx      = '0;
        shifted  = '0;
        cfg_ok   = (cfg_stride != '0) && (IW'(cfg_offset) < IW'(LEN));
        for (int k = 0; k < LEN; k++) begin
            idx = IW'(cfg_offset) + IW'(k) * IW'(cfg_stride);
            if (idx < IW'(LEN)) begin
                shifted     = in_data >> idx;
                gath_vec[k] = shifted[0];
                gath_cnt    = gath_cnt + CNT_W'(1);
            end
        end
    end

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        in_ready = (state_q == IDLE);
        accept   = in_valid && in_ready;
        take_par = accept && cfg_ok && !cfg_mode;
        take_ser = accept && cfg_ok && cfg_mode;
        take_bad = accept && !cfg_ok;
        ser_hs   = (state_q == SHIFT) && ser_ready;
        on_last  = (ser_rem_q == CNT_W'(1));
    end

    // FSM next state: a serial request enters SHIFT, the last handshake leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_ser) state_d = SHIFT;
            SHIFT:   if (ser_hs && on_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: parallel result capture, strobes and serial shifter.
    always_comb begin
        par_out_d   = par_out_q;
        par_count_d = par_count_q;
        par_valid_d = take_par;
        cfg_err_d   = take_bad;
        ser_data_d  = ser_data_q;
        ser_rem_d   = ser_rem_q;
        if (take_par) begin
            par_out_d   = gath_vec;
            par_count_d = gath_cnt;
        end
        if (take_ser) begin
            ser_data_d = gath_vec;
            ser_rem_d  = gath_cnt;
        end else if (ser_hs) begin
            ser_data_d = ser_data_q >> 1;
            ser_rem_d  = ser_rem_q - CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset; reset drops any stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            par_out_q   <= '0;
            par_count_q <= '0;
            par_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            ser_data_q  <= '0;
            ser_rem_q   <= '0;
        end else begin
            state_q     <= state_d;
            par_out_q   <= par_out_d;
            par_count_q <= par_count_d;
            par_valid_q <= par_valid_d;
            cfg_err_q   <= cfg_err_d;
            ser_data_q  <= ser_data_d;
            ser_rem_q   <= ser_rem_d;
        end
    end

    // Output drive; serial outputs are forced low outside SHIFT.
    always_comb begin
        busy      = (state_q == SHIFT);
        ser_valid = busy;
        ser_bit   = busy && ser_data_q[0];
        ser_last  = busy && on_last;
        par_out   = par_out_q;
        par_count = par_count_q;
        par_valid = par_valid_q;
        cfg_err   = cfg_err_q;
    end

endmodule

// File: tb/tb_stride_gather.sv
// Bench for stride_gather: directed cases plus randomized traffic, with a
// queue-based scoreboard filled by the driver and drained by a monitor.
module tb_stride_gather;

    localparam int LEN   = 8;
    localparam int CFG_W = 3;
    localparam int CNT_W = $clog2(LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LEN-1:0]   in_data;
    logic             in_valid;
    logic             in_ready;
    logic [CFG_W-1:0] cfg_stride;
    logic [CFG_W-1:0] cfg_offset;
    logic             cfg_mode;
    logic [LEN-1:0]   par_out;
    logic [CNT_W-1:0] par_count;
    logic             par_valid;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;
    logic             busy;
    logic             cfg_err;

    int n_checks = 0;
    int n_errors = 0;
    int par_pulses = 0;
    bit rand_ready = 1'b0;

    logic [LEN+CNT_W-1:0] par_q[$];
    logic [1:0]           ser_q[$];
    logic [0:0]           err_q[$];

    logic hold_prev = 1'b0;
    logic prev_bit  = 1'b0;
    logic prev_last = 1'b0;

    stride_gather #(.LEN(LEN), .CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_stride (cfg_stride),
        .cfg_offset (cfg_offset),
        .cfg_mode   (cfg_mode),
        .par_out    (par_out),
        .par_count  (par_count),
        .par_valid  (par_valid),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .ser_ready  (ser_ready),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the index sequence directly.
    task automatic model(input logic [LEN-1:0] d, input int stride, input int off,
                         output logic [LEN-1:0] v, output int n);
        v = '0;
        n = 0;
        for (int i = off; i < LEN; i += stride) begin
            v[n] = d[i];
            n++;
        end
    endtask

    task automatic expect_req(input logic [LEN-1:0] d, input int stride, input int off,
                              input logic mode);
        logic [LEN-1:0] v;
        int             n;
        if (stride == 0 || off >= LEN) begin
            err_q.push_back(1'b1);
        end else begin
            model(d, stride, off, v, n);
            if (!mode) par_q.push_back({CNT_W'(n), v});
            else for (int k = 0; k < n; k++) ser_q.push_back({(k == n - 1), v[k]});
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
        if (rand_ready) ser_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Driver: holds the request until accepted, then records the expectation.
    task automatic send(input logic [LEN-1:0] d, input int stride, input int off,
                        input logic mode);
        bit done = 1'b0;
        in_data    = d;
        cfg_stride = CFG_W'(stride);
        cfg_offset = CFG_W'(off);
        cfg_mode   = mode;
        in_valid   = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                expect_req(d, stride, off, mode);
                done = 1'b1;
            end
            align();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && (par_q.size() + ser_q.size() + err_q.size()) != 0; t++)
            align();
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        logic [LEN+CNT_W-1:0] pe;
        logic [1:0]           se;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            check("in_ready_vs_busy", in_ready, !busy);
            check("ser_valid_vs_busy", ser_valid, busy);
            if (par_valid) begin
                par_pulses++;
                check("par_in_shift", busy, 0);
                if (par_q.size() == 0) check("par_unexpected", 1, 0);
                else begin
                    pe = par_q.pop_front();
                    check("par_out", par_out, pe[LEN-1:0]);
                    check("par_count", par_count, pe[LEN+CNT_W-1:LEN]);
                end
            end
            if (hold_prev) begin
                check("ser_hold_valid", ser_valid, 1);
                check("ser_hold_bit", ser_bit, prev_bit);
                check("ser_hold_last", ser_last, prev_last);
            end
            if (ser_valid && ser_ready) begin
                if (ser_q.size() == 0) check("ser_unexpected", 1, 0);
                else begin
                    se = ser_q.pop_front();
                    check("ser_bit", ser_bit, se[0]);
                    check("ser_last", ser_last, se[1]);
                end
            end
            if (cfg_err) begin
                if (err_q.size() == 0) check("cfg_err_unexpected", 1, 0);
                else void'(err_q.pop_front());
            end
            hold_prev = ser_valid && !ser_ready;
            prev_bit  = ser_bit;
            prev_last = ser_last;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_par_out"}, par_out, 0);
        check({tag, "_par_count"}, par_count, 0);
        check({tag, "_par_valid"}, par_valid, 0);
        check({tag, "_ser_bit"}, ser_bit, 0);
        check({tag, "_ser_valid"}, ser_valid, 0);
        check({tag, "_ser_last"}, ser_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [2:0]     b032;
        logic [LEN-1:0] d;
        int             base;
        int             st;
        int             of;
        logic           md;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_stride = '0;
        cfg_offset = '0; cfg_mode = 1'b0; ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        align();

        // Parallel example: 0xB6, stride 2, offset 0 -> 0x06, count 4
        send(8'hB6, 2, 0, 1'b0);
        @(negedge clk);
        check("d031_par_valid", par_valid, 1);
        check("d031_par_out", par_out, 8'h06);
        check("d031_par_count", par_count, 4);
        @(negedge clk);
        check("d031_par_valid_drop", par_valid, 0);
        check("d031_par_out_hold", par_out, 8'h06);
        check("d031_par_count_hold", par_count, 4);
        align();

        // Serial example: 0x5A, stride 3, offset 1 -> 1,1,0
        b032 = 3'b011;
        send(8'h5A, 3, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d032_ser_valid", ser_valid, 1);
            check("d032_ser_bit", ser_bit, b032[i]);
            check("d032_ser_last", ser_last, (i == 2));
        end
        @(negedge clk);
        check("d032_in_ready_after", in_ready, 1);
        check("d032_ser_valid_after", ser_valid, 0);
        align();

        // Same stream, sink stalls for 3 cycles on bit 1
        send(8'h5A, 3, 1, 1'b1);
        align();
        ser_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d033_hold_valid", ser_valid, 1);
            check("d033_hold_bit", ser_bit, 1);
            check("d033_hold_last", ser_last, 0);
            if (i == 2) begin
                @(posedge clk);
                #1 ser_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("d033_last_bit", ser_bit, 0);
        check("d033_last_flag", ser_last, 1);
        @(negedge clk);
        check("d033_in_ready_after", in_ready, 1);
        align();

        // Rejected configuration: stride 0, both modes
        send(LEN'($urandom), 0, 3, 1'b0);
        @(negedge clk);
        check("d034_cfg_err", cfg_err, 1);
        check("d034_no_par", par_valid, 0);
        check("d034_no_ser", ser_valid, 0);
        check("d034_idle", busy, 0);
        @(negedge clk);
        check("d034_cfg_err_pulse", cfg_err, 0);
        align();
        send(LEN'($urandom), 0, 0, 1'b1);
        @(negedge clk);
        check("d034_cfg_err_ser", cfg_err, 1);
        check("d034_idle_ser", busy, 0);
        align();

        // Offset 7 with stride 5 -> a single bit
        d = LEN'($urandom);
        send(d, 5, 7, 1'b0);
        @(negedge clk);
        check("d034_single_count", par_count, 1);
        check("d034_single_out", par_out, {7'b0, d[7]});
        align();

        // Three back-to-back parallel requests
        base = par_pulses;
        for (int i = 0; i < 3; i++)
            send(LEN'($urandom), $urandom_range(1, 7), $urandom_range(0, 7), 1'b0);
        @(negedge clk);
        #1 check("d035_pulses", par_pulses - base, 3);
        align();

        // Randomized traffic with a random sink
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            st = $urandom_range(0, 7);
            of = $urandom_range(0, 7);
            md = 1'($urandom_range(0, 1));
            send(LEN'($urandom), st, of, md);
            repeat ($urandom_range(0, 2)) align();
        end
        drain();
        rand_ready = 1'b0;
        ser_ready  = 1'b1;
        drain();

        // Reset during the second serial bit
        send(8'hFF, 1, 0, 1'b1);
        align();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("d036");
        align();
        ser_q.delete();
        rst_n = 1'b1;
        align();
        send(8'hB6, 2, 0, 1'b0);
        drain();

        check("end_par_q_empty", par_q.size(), 0);
        check("end_ser_q_empty", ser_q.size(), 0);
        check("end_err_q_empty", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
